// File: rtl/sram_ctrl_pkg.sv
// Shared types for the single-port SRAM request controller.
package sram_ctrl_pkg;

    // Controller phase: optional zero-fill after reset, then normal traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response queue: up to two pushes per cycle (port a lands before port b),
// one pop per cycle, head presented from registered storage.
module sram_rsp_fifo #(
    parameter int  DEPTH = 4,
    parameter type entry_t = logic [64:0],
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_a,
    input  entry_t        data_a,
    input  logic          push_b,
    input  entry_t        data_b,
    input  logic          pop,
    output entry_t        head,
    output logic          not_empty,
    output logic [CW-1:0] occupancy
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop_ok;

    // Pointer advance with wrap, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign not_empty = (count != '0);
    assign occupancy = count;
    assign pop_ok    = pop & not_empty;
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // Storage write: when both ports push, b goes one slot after a.
    always_ff @(posedge clk) begin
        if (push_a) begin
            mem[wr_ptr] <= data_a;
        end
        if (push_b) begin
            mem[push_a ? ptr_inc(wr_ptr) : wr_ptr] <= data_b;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_a && push_b) begin
                wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            end else if (push_a || push_b) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push_a) + CW'(push_b) - CW'(pop_ok);
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Front-end for a single-port byte-enable SRAM with 1-cycle read latency:
// turns a valid/ready request stream into SRAM strobes and returns in-order
// responses through a buffered queue, with optional zero-fill after reset.
module sram_1rw_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH     = 64,
    parameter int  DATA_DEPTH     = 1024,
    parameter int  RSP_DEPTH      = 4,
    parameter bit  CLEAR_ON_RESET = 1'b0,
    localparam int ADDR_WIDTH     = $clog2(DATA_DEPTH),
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dataw,
    output logic [BE_WIDTH-1:0]   sram_be,
    input  logic [DATA_WIDTH-1:0] sram_datar
);

    localparam int OCC_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                  is_write;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;

    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  inflight;
    logic                  issue;
    logic [OCC_W-1:0]      occupancy;
    rsp_entry_t            rd_entry;
    rsp_entry_t            wr_entry;
    rsp_entry_t            head;

    // Credit check uses only registered state: queued entries plus the read
    // whose data lands next cycle must leave room for one more request,
    // which can add two pushes (pending read data plus a write ack).
    assign req_ready = (state == RUN) &&
                       (({1'b0, occupancy} + (OCC_W + 1)'(inflight)) < (OCC_W + 1)'(RSP_DEPTH));
    assign issue     = req_valid & req_ready;

    assign rd_entry.is_write = 1'b0;
    assign rd_entry.rdata    = sram_datar;
    assign wr_entry.is_write = 1'b1;
    assign wr_entry.rdata    = '0;

    // Phase FSM, zero-fill address counter and read-in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr  <= '0;
            init_done <= !CLEAR_ON_RESET;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue & ~req_we;
            if (state == CLEAR) begin
                if (clr_addr == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
            end
        end
    end

    // SRAM port strobes: zero-fill writes during CLEAR, request passthrough in RUN.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_dataw = '0;
        sram_be    = '0;
        if (state == CLEAR) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = clr_addr;
            sram_be   = '1;
        end else if (issue) begin
            sram_ce    = 1'b1;
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_dataw = req_wdata;
            sram_be    = req_be;
        end
    end

    // Read data (from last cycle's issue) is pushed on port a ahead of this
    // cycle's write ack on port b, keeping responses in request order.
    sram_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_a    (inflight),
        .data_a    (rd_entry),
        .push_b    (issue & req_we),
        .data_b    (wr_entry),
        .pop       (rsp_valid & rsp_ready),
        .head      (head),
        .not_empty (rsp_valid),
        .occupancy (occupancy)
    );

    assign rsp_is_write = head.is_write;
    assign rsp_rdata    = head.rdata;

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Scoreboard bench for sram_1rw_req_ctrl with a behavioural byte-enable SRAM.
module tb_sram_1rw_req_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_is_write;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dataw;
    logic [BW-1:0] sram_be;
    logic [DW-1:0] sram_datar;

    sram_1rw_req_ctrl #(
        .DATA_WIDTH     (DW),
        .DATA_DEPTH     (DEPTH),
        .RSP_DEPTH      (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_is_write (rsp_is_write),
        .rsp_rdata    (rsp_rdata),
        .init_done    (init_done),
        .sram_ce      (sram_ce),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_dataw   (sram_dataw),
        .sram_be      (sram_be),
        .sram_datar   (sram_datar)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte-enable write, 1-cycle read, read data held.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        sram_datar = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_dataw[8*b +: 8];
            end else begin
                sram_datar <= mem[sram_addr];
            end
        end
    end

    typedef struct packed {
        logic          w;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every accepted response is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got is_write=%0d rdata=%h expected no response",
                         rsp_is_write, rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_is_write", 64'(rsp_is_write), 64'(mon_e.w));
                check("rsp_rdata", rsp_rdata, mon_e.d);
            end
        end
    end

    // Issue one request; entered and left just after a rising edge.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic [DW-1:0] exp_d, output int stalls);
        exp_t e;
        bit   ok;
        stalls    = 0;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: got req_ready=0 expected 1 within 50 cycles");
            @(posedge clk);
        end else begin
            @(posedge clk);
            e.w = we;
            e.d = exp_d;
            exp_q.push_back(e);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    int stalls;
    int total_stalls;
    int n;
    int acc;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_is_write", 64'(rsp_is_write), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-fill sweep: one write per cycle, addresses 0..15.
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (init_done) break;
            check("clr_strobes", {54'd0, sram_ce, sram_we, sram_be}, {54'd0, 10'h3FF});
            check("clr_addr", 64'(sram_addr), 64'(n));
            check("clr_dataw", sram_dataw, 64'd0);
            check("clr_req_ready", 64'(req_ready), 64'd0);
            n++;
        end
        check("clr_cycles", 64'(n), 64'd16);
        check("run_init_done", 64'(init_done), 64'd1);
        check("run_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Cleared word reads back as zero.
        issue(1'b0, 4'd5, '0, '0, 64'd0, stalls);
        drain();

        // Full write, partial byte-enable write, read-back merge.
        issue(1'b1, 4'd3, 64'h1122334455667788, 8'hFF, 64'd0, stalls);
        issue(1'b1, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0, stalls);
        issue(1'b0, 4'd3, '0, '0, 64'h11223344AAAAAAAA, stalls);
        drain();

        // Back-to-back writes then reads with rsp_ready held high.
        for (int a = 0; a < 8; a++)
            issue(1'b1, AW'(a), 64'h100 + 64'(a), 8'hFF, 64'd0, stalls);
        total_stalls = 0;
        for (int a = 0; a < 8; a++) begin
            issue(1'b0, AW'(a), '0, '0, 64'h100 + 64'(a), stalls);
            total_stalls += stalls;
        end
        check("b2b_read_stalls", 64'(total_stalls), 64'd0);
        drain();

        // Backpressure: four reads fit, then req_ready must drop.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd4;
        acc       = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                mon_e.w = 1'b0;
                mon_e.d = 64'h100 + 64'(req_addr);
                exp_q.push_back(mon_e);
                acc++;
                #1 req_addr = req_addr + 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // Read, write to the same address next cycle, read again.
        issue(1'b0, 4'd2, '0, '0, 64'h102, stalls);
        issue(1'b1, 4'd2, 64'hDEAD, 8'hFF, 64'd0, stalls);
        issue(1'b0, 4'd2, '0, '0, 64'hDEAD, stalls);
        drain();

        // Reset with three responses queued and a read in flight.
        rsp_ready = 1'b0;
        for (int a = 0; a < 4; a++)
            issue(1'b0, AW'(a), '0, '0, 64'h100 + 64'(a), stalls);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_init_done", 64'(init_done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("reclr_start_addr", 64'(sram_addr), 64'd0);
        check("reclr_ce", 64'(sram_ce), 64'd1);
        for (int t = 0; t < 40 && !init_done; t++) @(negedge clk);
        check("reclr_init_done", 64'(init_done), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        issue(1'b0, 4'd5, '0, '0, 64'd0, stalls);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
